// File: rtl/uart_pkg.sv
// Shared UART definitions, reused by the receiver and the future transmitter.
// Contents: serial FSM state encoding and the default clocks-per-bit constant
// (100 MHz / 115200 baud).
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    localparam int unsigned CLK_DIV_DEFAULT = 868;

endpackage

// File: rtl/uart_rx_if.sv
// Valid/ready byte stream between the receive FIFO and its consumer.
//   data  : byte at the head of the stream
//   valid : data holds a byte
//   ready : consumer accepts data this cycle (transfer on valid && ready)
// master drives data/valid, slave drives ready.
interface uart_rx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_fifo.sv
// Receive FIFO with sticky overflow flag.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_i        : write push_data_i this cycle
//   push_data_i   : byte to store
//   ovf_clr_i     : synchronous clear of overflow_o (a new drop wins)
//   overflow_o    : sticky, set when a push is dropped because the FIFO is full
//   rd            : read side, head entry on rd.data, rd.valid = not empty
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             ovf_clr_i,
    output logic             overflow_o,
    uart_rx_if.master        rd
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Extra MSB on each pointer separates full from empty when indices match.
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             overflow_q;

    logic empty;
    logic full;
    logic pop;
    logic wr_en;
    logic drop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = rd.ready && !empty;
    // A pop in the same cycle frees the slot, so a push while full is kept.
    assign wr_en = push_i && (!full || pop);
    assign drop  = push_i && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_q[AW-1:0]] <= push_data_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign rd.valid   = !empty;
    assign rd.data    = mem_q[rd_q[AW-1:0]];
    assign overflow_o = overflow_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, no parity, 1 stop bit, LSB first.
// Ports:
//   clk            : system clock, rising edge
//   reset_async    : asynchronous active-low reset (release already synchronized)
//   rs232_dce_rxd  : serial input, asynchronous, idle high
//   rx_data        : byte at FIFO head
//   rx_valid       : FIFO not empty
//   rx_ready       : consumer accepts rx_data this cycle
//   frame_err      : one-cycle pulse on a bad stop bit
//   overflow       : sticky, byte dropped on full FIFO
//   ovf_clr        : synchronous clear of overflow
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_async,
    input  logic       rs232_dce_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overflow,
    input  logic       ovf_clr
);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    uart_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          frame_err_q;

    logic rxd_s;
    logic fall;
    logic push;

    assign rxd_s = sync_q[1];
    // prev_q tracks the line every cycle, so after a bad (low) stop bit a new
    // start is only accepted once the line has been seen high again.
    assign fall  = prev_q && !rxd_s;
    // Push on the stop-sample edge itself so the byte is visible one cycle later.
    assign push  = (state_q == ST_STOP) && (cnt_q == '0) && rxd_s;

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            sync_q      <= 2'b11;
            prev_q      <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rs232_dce_rxd};
            prev_q      <= rxd_s;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_q <= ST_START;
                        cnt_q   <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rxd_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DATA;
                        cnt_q   <= FULL_LOAD;
                        bit_q   <= '0;
                    end
                end
                ST_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q <= {rxd_s, shift_q[7:1]};
                        cnt_q   <= FULL_LOAD;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        frame_err_q <= !rxd_s;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_rx_if #(.WIDTH(8)) rd_if ();

    assign rd_if.ready = rx_ready;
    assign rx_data     = rd_if.data;
    assign rx_valid    = rd_if.valid;
    assign frame_err   = frame_err_q;

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset_async),
        .push_i      (push),
        .push_data_i (shift_q),
        .ovf_clr_i   (ovf_clr),
        .overflow_o  (overflow),
        .rd          (rd_if)
    );
endmodule
